// File: rtl/exec_control_unit_pkg.sv
// Shared definitions for the execute stage: state encodings, opcode
// constants, the LDI marker bit and a small instruction decoder.
package exec_control_unit_pkg;

    localparam int DATA_W  = 8;
    localparam int INSTR_W = 8;
    localparam int NREG    = 4;
    localparam int LDI_BIT = 7;

    // cu_state encodings; the sequencer waits for CU_DONE
    typedef enum logic [1:0] {
        CU_IDLE = 2'b00,
        CU_READ = 2'b01,
        CU_EXEC = 2'b10,
        CU_DONE = 2'b11
    } cu_state_e;

    // 3-bit opcode field for non-LDI instructions
    localparam logic [2:0] OPC_NOP = 3'b000;
    localparam logic [2:0] OPC_MOV = 3'b001;
    localparam logic [2:0] OPC_ADD = 3'b010;
    localparam logic [2:0] OPC_SUB = 3'b011;
    localparam logic [2:0] OPC_AND = 3'b100;
    localparam logic [2:0] OPC_OR  = 3'b101;
    localparam logic [2:0] OPC_XOR = 3'b110;
    localparam logic [2:0] OPC_NOT = 3'b111;

    // Operation selector handed to the ALU
    typedef enum logic [3:0] {
        ALU_NOP,
        ALU_MOV,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOT,
        ALU_LDI
    } alu_op_e;

    function automatic alu_op_e decode_op(input logic [INSTR_W-1:0] ir);
        alu_op_e op;
        op = ALU_NOP;
        if (ir[LDI_BIT]) begin
            op = ALU_LDI;
        end else begin
            case (ir[6:4])
                OPC_NOP: op = ALU_NOP;
                OPC_MOV: op = ALU_MOV;
                OPC_ADD: op = ALU_ADD;
                OPC_SUB: op = ALU_SUB;
                OPC_AND: op = ALU_AND;
                OPC_OR:  op = ALU_OR;
                OPC_XOR: op = ALU_XOR;
                OPC_NOT: op = ALU_NOT;
                default: op = ALU_NOP;
            endcase
        end
        return op;
    endfunction

    // Destination register: LDI keeps it in [6:5], register ops in [3:2]
    function automatic logic [1:0] decode_rd(input logic [INSTR_W-1:0] ir);
        return ir[LDI_BIT] ? ir[6:5] : ir[3:2];
    endfunction

    function automatic logic [1:0] decode_rs(input logic [INSTR_W-1:0] ir);
        return ir[1:0];
    endfunction

endpackage

// File: rtl/exec_control_unit_alu.sv
// Combinational ALU for the execute stage. Reports whether the operation
// writes the register file and whether it updates the carry flag.
module cu_alu
    import exec_control_unit_pkg::*;
(
    input  alu_op_e           op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [4:0]        imm_i,
    output logic [DATA_W-1:0] res_o,
    output logic              carry_o,
    output logic              carry_we_o,
    output logic              writes_o
);

    logic [DATA_W:0] sum_ext;

    assign sum_ext = {1'b0, a_i} + {1'b0, b_i};

    // Operation select; only ADD/SUB touch the carry, only NOP skips the write
    always_comb begin
        res_o      = '0;
        carry_o    = 1'b0;
        carry_we_o = 1'b0;
        writes_o   = 1'b1;
        case (op_i)
            ALU_MOV: res_o = b_i;
            ALU_ADD: begin
                res_o      = sum_ext[DATA_W-1:0];
                carry_o    = sum_ext[DATA_W];
                carry_we_o = 1'b1;
            end
            ALU_SUB: begin
                res_o      = a_i - b_i;
                carry_o    = (a_i < b_i);
                carry_we_o = 1'b1;
            end
            ALU_AND: res_o = a_i & b_i;
            ALU_OR:  res_o = a_i | b_i;
            ALU_XOR: res_o = a_i ^ b_i;
            ALU_NOT: res_o = ~b_i;
            ALU_LDI: res_o = {{(DATA_W-5){1'b0}}, imm_i};
            default: writes_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_control_unit.sv
// Execute stage: captures an instruction on ir_load, steps through
// READ/EXEC/DONE against a small register file and signals DONE for one
// cycle so the sequencer can advance.
module exec_control_unit
    import exec_control_unit_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               ir_load,
    input  logic [INSTR_W-1:0] instr,
    output logic [1:0]         cu_state,
    output logic [DATA_W-1:0]  result,
    output logic               zero_flag,
    output logic               carry_flag,
    output logic               busy_err,
    input  logic [1:0]         dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    cu_state_e          state_q;
    logic [INSTR_W-1:0] ir_q;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic [DATA_W-1:0]  result_q;
    logic               zero_q;
    logic               carry_q;
    logic               busy_err_q;
    logic [DATA_W-1:0]  regs_q [NREG];

    alu_op_e            alu_op;
    logic [1:0]         rd;
    logic [1:0]         rs;
    logic [DATA_W-1:0]  alu_res;
    logic               alu_carry;
    logic               alu_carry_we;
    logic               alu_writes;
    logic               reg_we;

    assign alu_op = decode_op(ir_q);
    assign rd     = decode_rd(ir_q);
    assign rs     = decode_rs(ir_q);

    cu_alu u_alu (
        .op_i       (alu_op),
        .a_i        (a_q),
        .b_i        (b_q),
        .imm_i      (ir_q[4:0]),
        .res_o      (alu_res),
        .carry_o    (alu_carry),
        .carry_we_o (alu_carry_we),
        .writes_o   (alu_writes)
    );

    // The write happens on the edge that leaves EXEC; only writing ops reach EXEC
    assign reg_we = (state_q == CU_EXEC);

    // One register per generate slice, cleared by reset, written at EXEC exit
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            always_ff @(posedge clk) begin
                if (!reset) begin
                    regs_q[gi] <= '0;
                end else if (reg_we && (rd == 2'(gi))) begin
                    regs_q[gi] <= alu_res;
                end
            end
        end
    endgenerate

    // Sequencing FSM with operand latches, result/flag registers and busy detection
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= CU_IDLE;
            ir_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            busy_err_q <= 1'b0;
        end else begin
            busy_err_q <= ir_load && (state_q != CU_IDLE);
            case (state_q)
                CU_IDLE: begin
                    if (ir_load) begin
                        ir_q    <= instr;
                        state_q <= CU_READ;
                    end
                end
                CU_READ: begin
                    a_q     <= regs_q[rd];
                    b_q     <= regs_q[rs];
                    state_q <= alu_writes ? CU_EXEC : CU_DONE;
                end
                CU_EXEC: begin
                    result_q <= alu_res;
                    zero_q   <= (alu_res == '0);
                    if (alu_carry_we) begin
                        carry_q <= alu_carry;
                    end
                    state_q  <= CU_DONE;
                end
                CU_DONE: begin
                    state_q <= CU_IDLE;
                end
                default: state_q <= CU_IDLE;
            endcase
        end
    end

    assign cu_state   = state_q;
    assign result     = result_q;
    assign zero_flag  = zero_q;
    assign carry_flag = carry_q;
    assign busy_err   = busy_err_q;
    // Debug port reads the array directly so a same-cycle write shows only after the edge
    assign dbg_data   = regs_q[dbg_addr];

endmodule

// File: tb/tb_exec_control_unit.sv
// Directed bench for exec_control_unit with a reference model feeding a
// scoreboard that is drained when the DUT reports DONE.
module tb_exec_control_unit;

    logic       clk;
    logic       reset;
    logic       ir_load;
    logic [7:0] instr;
    logic [1:0] cu_state;
    logic [7:0] result;
    logic       zero_flag;
    logic       carry_flag;
    logic       busy_err;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] result;
        logic       zero;
        logic       carry;
        logic [1:0] rd;
        logic [7:0] rdval;
        logic [7:0] ins;
    } exp_t;

    exp_t sb[$];

    logic [7:0] m_regs [4];
    logic [7:0] m_result;
    logic       m_zero;
    logic       m_carry;

    exec_control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .ir_load    (ir_load),
        .instr      (instr),
        .cu_state   (cu_state),
        .result     (result),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag),
        .busy_err   (busy_err),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_result = 8'h00;
        m_zero   = 1'b0;
        m_carry  = 1'b0;
        sb.delete();
    endtask

    // Reference behaviour of one instruction; pushes the expected DONE view
    task automatic model_exec(input logic [7:0] ins, output bit w, output logic [1:0] rd);
        logic [7:0] a, b, r;
        logic [8:0] s;
        exp_t e;
        w = 1'b1;
        r = 8'h00;
        if (ins[7]) begin
            rd = ins[6:5];
            r  = {3'b000, ins[4:0]};
        end else begin
            rd = ins[3:2];
            a  = m_regs[ins[3:2]];
            b  = m_regs[ins[1:0]];
            case (ins[6:4])
                3'd0: w = 1'b0;
                3'd1: r = b;
                3'd2: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; m_carry = s[8]; end
                3'd3: begin r = a - b; m_carry = (a < b); end
                3'd4: r = a & b;
                3'd5: r = a | b;
                3'd6: r = a ^ b;
                default: r = ~b;
            endcase
        end
        if (w) begin
            m_regs[rd] = r;
            m_result   = r;
            m_zero     = (r == 8'h00);
        end
        e.result = m_result;
        e.zero   = m_zero;
        e.carry  = m_carry;
        e.rd     = rd;
        e.rdval  = m_regs[rd];
        e.ins    = ins;
        sb.push_back(e);
    endtask

    // Issue one instruction at a negedge and follow it cycle by cycle.
    // busy_at>0 drives a stray ir_load after the check of that cycle index.
    task automatic run_instr(input logic [7:0] ins, input int busy_at);
        bit         w;
        logic [1:0] rd;
        logic [1:0] seq [4];
        int         n;
        exp_t       e;
        model_exec(ins, w, rd);
        if (w) begin
            seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b00; n = 4;
        end else begin
            seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b00; seq[3] = 2'b00; n = 3;
        end
        dbg_addr = rd;
        instr    = ins;
        ir_load  = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            chk($sformatf("state_%02h_c%0d", ins, k), {30'd0, cu_state}, {30'd0, seq[k-1]});
            chk($sformatf("busy_%02h_c%0d", ins, k), {31'd0, busy_err},
                {31'd0, (busy_at != 0) && (k - 1 == busy_at)});
            if (cu_state == 2'b11) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("result_%02h", e.ins), {24'd0, result}, {24'd0, e.result});
                    chk($sformatf("zero_%02h", e.ins), {31'd0, zero_flag}, {31'd0, e.zero});
                    chk($sformatf("carry_%02h", e.ins), {31'd0, carry_flag}, {31'd0, e.carry});
                    chk($sformatf("rdval_%02h", e.ins), {24'd0, dbg_data}, {24'd0, e.rdval});
                end
            end
            ir_load = (k == busy_at);
            instr   = (k == busy_at) ? 8'hFF : ins;
        end
        ir_load = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            chk($sformatf("%s_r%0d", tag, i), {24'd0, dbg_data}, {24'd0, m_regs[i]});
        end
    endtask

    initial begin
        reset    = 1'b0;
        ir_load  = 1'b0;
        instr    = 8'h00;
        dbg_addr = 2'd0;
        model_reset();

        // 1: reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_state", {30'd0, cu_state}, 32'd0);
        chk("rst_result", {24'd0, result}, 32'd0);
        chk("rst_zero", {31'd0, zero_flag}, 32'd0);
        chk("rst_carry", {31'd0, carry_flag}, 32'd0);
        chk("rst_busy", {31'd0, busy_err}, 32'd0);
        check_regs("rst");
        reset = 1'b1;
        @(negedge clk);

        // 2: LDI r1,#5
        run_instr(8'hA5, 0);
        check_regs("ldi");

        // 3: NOT / ADD wrap with carry and zero
        run_instr(8'h80, 0);
        run_instr(8'h74, 0);
        run_instr(8'hC1, 0);
        run_instr(8'h26, 0);
        check_regs("add");

        // 4: SUB with borrow
        run_instr(8'h83, 0);
        run_instr(8'hE5, 0);
        run_instr(8'h33, 0);
        check_regs("sub");

        // Logic ops and MOV keep carry; a busy ir_load during DONE is ignored
        run_instr(8'h18, 0);
        run_instr(8'h69, 3);
        run_instr(8'h47, 0);
        run_instr(8'h5B, 0);
        check_regs("logic");

        // 5: NOP with a stray ir_load during READ
        run_instr(8'h00, 1);
        @(negedge clk);
        chk("nop_idle", {30'd0, cu_state}, 32'd0);
        chk("nop_busy_gone", {31'd0, busy_err}, 32'd0);
        check_regs("nop");

        // 6: reset while an ADD sits in EXEC
        run_instr(8'hA5, 0);
        instr   = 8'h25;
        ir_load = 1'b1;
        @(negedge clk);
        ir_load = 1'b0;
        chk("abort_read", {30'd0, cu_state}, 32'd1);
        @(negedge clk);
        chk("abort_exec", {30'd0, cu_state}, 32'd2);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        chk("abort_state", {30'd0, cu_state}, 32'd0);
        chk("abort_result", {24'd0, result}, 32'd0);
        chk("abort_carry", {31'd0, carry_flag}, 32'd0);
        check_regs("abort");

        // ir_load together with reset: reset wins
        reset   = 1'b0;
        ir_load = 1'b1;
        instr   = 8'hA5;
        @(negedge clk);
        chk("rstload_state", {30'd0, cu_state}, 32'd0);
        reset   = 1'b1;
        ir_load = 1'b0;
        @(negedge clk);
        chk("rstload_idle", {30'd0, cu_state}, 32'd0);
        check_regs("rstload");

        // Normal operation resumes
        run_instr(8'hDF, 0);
        check_regs("final");
        chk("sb_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
